// File: rtl/pcileech_ft601_emu.sv
// pcileech_ft601_emu: chip-side FT601/FT245 sync-FIFO responder bridging the controller pads to host valid/ready streams.
// Optional macro FT601_EMU_THROTTLE_EN adds periodic forced-full windows on ft_txe_n.

module pcileech_ft601_emu_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [31:0]         push_data_i,
  input  logic                pop_i,
  output logic [31:0]         head_o,
  output logic [DEPTH_LOG2:0] count_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           head_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop_i);
    count_d  = count_q + (DEPTH_LOG2+1)'(push_i) - (DEPTH_LOG2+1)'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  // Head register reads the next read address; bypass covers a push landing on that address.
  // It only reloads while a word remains, so an emptied FIFO keeps presenting its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else if (count_d != '0) begin
      head_q <= (push_i && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;
endmodule

module pcileech_ft601_emu #(
  parameter int DEPTH_LOG2      = 9,
  parameter int TXE_MARGIN      = 4,
  parameter int THROTTLE_PERIOD = 64,
  parameter int THROTTLE_LEN    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ft_data_in,
  input  logic [3:0]  ft_be_in,
  output logic [31:0] ft_data_out,
  output logic [3:0]  ft_be_out,
  output logic        ft_data_oe,
  output logic        ft_rxf_n,
  output logic        ft_txe_n,
  input  logic        ft_wr_n,
  input  logic        ft_rd_n,
  input  logic        ft_oe_n,
  input  logic [31:0] host_tx_data,
  input  logic        host_tx_valid,
  output logic        host_tx_ready,
  output logic [31:0] host_rx_data,
  output logic        host_rx_valid,
  input  logic        host_rx_ready,
  output logic [15:0] drop_cnt,
  output logic        proto_err
);
  localparam int            CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] MARGIN_C = CW'(TXE_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_RD_OE, S_RD, S_WR} state_t;

  state_t        state_q;
  logic          data_oe_q, rxf_n_q, txe_n_q, tx_ready_q, proto_err_q;
  logic [15:0]   drop_cnt_q;
  logic [31:0]   down_head, up_head;
  logic [CW-1:0] down_cnt, up_cnt, down_cnt_d, up_free;
  logic          down_push, down_pop, up_push, up_pop, wr_cycle, up_full, txe_force;

  pcileech_ft601_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_down (
    .clk(clk), .rst(rst), .push_i(down_push), .push_data_i(host_tx_data),
    .pop_i(down_pop), .head_o(down_head), .count_o(down_cnt)
  );

  pcileech_ft601_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_up (
    .clk(clk), .rst(rst), .push_i(up_push), .push_data_i(ft_data_in),
    .pop_i(up_pop), .head_o(up_head), .count_o(up_cnt)
  );

  assign up_full    = (up_cnt == DEPTH_C);
  assign up_free    = DEPTH_C - up_cnt;
  assign down_push  = host_tx_valid && tx_ready_q;
  assign down_pop   = (state_q == S_RD) && !ft_rd_n && (down_cnt != '0);
  // A write strobe is taken straight from idle unless a read turnaround wins the same cycle.
  assign wr_cycle   = !ft_wr_n && (((state_q == S_IDLE) && ft_oe_n) || (state_q == S_WR));
  assign up_push    = wr_cycle && !up_full;
  assign up_pop     = host_rx_valid && host_rx_ready;
  assign down_cnt_d = down_cnt + CW'(down_push) - CW'(down_pop);

`ifdef FT601_EMU_THROTTLE_EN
  localparam int TW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  logic [TW-1:0] thr_q;

  always_ff @(posedge clk) begin
    if (rst || (thr_q == TW'(THROTTLE_PERIOD - 1))) thr_q <= '0;
    else thr_q <= thr_q + TW'(1);
  end

  assign txe_force = (thr_q < TW'(THROTTLE_LEN));
`else
  // Never asserts; keeps the throttle parameters referenced when the feature is compiled out.
  assign txe_force = (THROTTLE_PERIOD == 0) && (THROTTLE_LEN < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b1;
      tx_ready_q  <= 1'b0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rxf_n_q    <= (down_cnt == '0);
      txe_n_q    <= (up_free < MARGIN_C) || txe_force;
      tx_ready_q <= (down_cnt_d != DEPTH_C);
      if (wr_cycle && up_full && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if ((!ft_wr_n && data_oe_q) || (!ft_rd_n && ft_oe_n) || (wr_cycle && (ft_be_in != 4'hF)))
        proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_oe_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!ft_oe_n) begin
            state_q   <= S_RD_OE;
            data_oe_q <= 1'b1;
          end else if (!ft_wr_n) begin
            state_q <= S_WR;
          end
        end
        S_RD_OE: begin
          if (ft_oe_n) begin
            state_q   <= S_IDLE;
            data_oe_q <= 1'b0;
          end else if (!ft_rd_n) begin
            state_q <= S_RD;
          end
        end
        S_RD: begin
          if (ft_oe_n) begin
            state_q   <= S_IDLE;
            data_oe_q <= 1'b0;
          end else if (ft_rd_n) begin
            state_q <= S_RD_OE;
          end
        end
        S_WR: begin
          if (ft_wr_n) state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign ft_data_out   = data_oe_q ? down_head : 32'h0;
  assign ft_be_out     = data_oe_q ? 4'hF : 4'h0;
  assign ft_data_oe    = data_oe_q;
  assign ft_rxf_n      = rxf_n_q;
  assign ft_txe_n      = txe_n_q;
  assign host_tx_ready = tx_ready_q;
  assign host_rx_data  = up_head;
  assign host_rx_valid = (up_cnt != '0);
  assign drop_cnt      = drop_cnt_q;
  assign proto_err     = proto_err_q;
endmodule

// File: tb/tb_pcileech_ft601_emu.sv
// Bench for pcileech_ft601_emu: directed steps with random data, checked against queue models of both FIFOs.
`timescale 1ns/1ps
module tb_pcileech_ft601_emu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ft_data_in, host_tx_data;
  logic [3:0]  ft_be_in;
  logic        ft_wr_n, ft_rd_n, ft_oe_n, host_tx_valid, host_rx_ready;

  logic [31:0] m_data_out, m_rx_data, s_data_out, s_rx_data;
  logic [3:0]  m_be_out, s_be_out;
  logic        m_oe, m_rxf_n, m_txe_n, m_tx_ready, m_rx_valid, m_perr;
  logic        s_oe, s_rxf_n, s_txe_n, s_tx_ready, s_rx_valid, s_perr;
  logic [15:0] m_drop, s_drop;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] dq[$];
  logic [31:0] uq[$];

  always #5 clk = ~clk;

  pcileech_ft601_emu dut_m (
    .clk(clk), .rst(rst), .ft_data_in(ft_data_in), .ft_be_in(ft_be_in),
    .ft_data_out(m_data_out), .ft_be_out(m_be_out), .ft_data_oe(m_oe),
    .ft_rxf_n(m_rxf_n), .ft_txe_n(m_txe_n), .ft_wr_n(ft_wr_n), .ft_rd_n(ft_rd_n),
    .ft_oe_n(ft_oe_n), .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(m_tx_ready), .host_rx_data(m_rx_data), .host_rx_valid(m_rx_valid),
    .host_rx_ready(host_rx_ready), .drop_cnt(m_drop), .proto_err(m_perr)
  );

  pcileech_ft601_emu #(.DEPTH_LOG2(3)) dut_s (
    .clk(clk), .rst(rst), .ft_data_in(ft_data_in), .ft_be_in(ft_be_in),
    .ft_data_out(s_data_out), .ft_be_out(s_be_out), .ft_data_oe(s_oe),
    .ft_rxf_n(s_rxf_n), .ft_txe_n(s_txe_n), .ft_wr_n(ft_wr_n), .ft_rd_n(ft_rd_n),
    .ft_oe_n(ft_oe_n), .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(s_tx_ready), .host_rx_data(s_rx_data), .host_rx_valid(s_rx_valid),
    .host_rx_ready(host_rx_ready), .drop_cnt(s_drop), .proto_err(s_perr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    dq.delete();
    uq.delete();
  endtask

  // Host fills the down FIFO, controller reads it back; in random mode the host keeps pushing during reads.
  task automatic run_read(input int n, input bit rnd);
    logic [31:0] w, last;
    int pushed, popped, cyc, pre;
    bit do_push;
    pushed = 0; popped = 0; cyc = 0; last = '0;
    pre = rnd ? n / 2 : n;
    ft_oe_n = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1;
    w = rnd ? $urandom : 32'h11111111;
    while (pushed < pre && cyc < 500) begin
      host_tx_data  = w;
      host_tx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      do_push = host_tx_valid && m_tx_ready;
      tick(); cyc++;
      if (do_push) begin
        dq.push_back(w); pushed++;
        w = rnd ? $urandom : 32'h11111111 * (pushed + 1);
      end
    end
    host_tx_valid = 1'b0;
    tick(); tick();
    check("rxf_n_nonempty", m_rxf_n, 1'b0);
    ft_oe_n = 1'b0;
    tick();
    check("oe_data_oe", m_oe, 1'b1);
    check("oe_be_out", m_be_out, 4'hF);
    check("oe_head", m_data_out, dq[0]);
    ft_rd_n = 1'b0;
    tick();
    cyc = 0;
    while (popped < n && cyc < 500) begin
      if (pushed < n) begin
        host_tx_data  = w;
        host_tx_valid = 1'($urandom_range(0, 1));
      end else begin
        host_tx_valid = 1'b0;
      end
      do_push = host_tx_valid && m_tx_ready;
      if (dq.size() > 0) begin
        check("rd_data", m_data_out, dq[0]);
        last = dq.pop_front();
        popped++;
      end else begin
        check("rd_hold_empty", m_data_out, last);
      end
      tick(); cyc++;
      if (do_push) begin
        dq.push_back(w); pushed++;
        w = $urandom;
      end
    end
    host_tx_valid = 1'b0;
    check("rd_count", popped, n);
    ft_rd_n = 1'b1;
    tick();
    check("rxf_n_drained", m_rxf_n, 1'b1);
    check("data_oe_held", m_oe, 1'b1);
    ft_oe_n = 1'b1;
    tick();
    check("data_oe_off", m_oe, 1'b0);
    $display("[TB] read burst n=%0d rnd=%0d popped=%0d", n, rnd, popped);
  endtask

  // Controller writes n words back to back; host drains the up FIFO, randomly stalling in random mode.
  task automatic run_write(input int n, input bit rnd);
    logic [31:0] w;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    ft_be_in = 4'hF; ft_oe_n = 1'b1; ft_rd_n = 1'b1;
    while ((sent < n || got < n) && cyc < 500) begin
      w = rnd ? $urandom : 32'(sent);
      ft_data_in = w;
      ft_wr_n = (sent < n) ? 1'b0 : 1'b1;
      host_rx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("rx_valid", m_rx_valid, uq.size() != 0);
      if (uq.size() != 0 && host_rx_ready) begin
        check("rx_data", m_rx_data, uq[0]);
        void'(uq.pop_front());
        got++;
      end
      if (sent < n) begin
        uq.push_back(w); sent++;
      end
      tick(); cyc++;
    end
    ft_wr_n = 1'b1;
    host_rx_ready = 1'b0;
    check("rx_count", got, n);
    check("drop_cnt_zero", m_drop, 16'd0);
    check("perr_clean_write", m_perr, 1'b0);
    $display("[TB] write burst n=%0d rnd=%0d received=%0d", n, rnd, got);
  endtask

  initial begin
    int txe_hi, exp_txe_hi;
    logic [31:0] w;
    rst = 1'b1; ft_data_in = '0; ft_be_in = 4'hF; ft_wr_n = 1'b1; ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    host_tx_data = '0; host_tx_valid = 1'b0; host_rx_ready = 1'b0;
    tick(); tick();
    check("rst_rxf_n", m_rxf_n, 1'b1);
    check("rst_txe_n", m_txe_n, 1'b1);
    check("rst_data_oe", m_oe, 1'b0);
    check("rst_data_out", m_data_out, 32'h0);
    check("rst_be_out", m_be_out, 4'h0);
    check("rst_tx_ready", m_tx_ready, 1'b0);
    check("rst_rx_valid", m_rx_valid, 1'b0);
    check("rst_drop", m_drop, 16'd0);
    check("rst_perr", m_perr, 1'b0);
    rst = 1'b0;
    repeat (10) tick();
    check("idle_rxf_n", m_rxf_n, 1'b1);
    check("idle_txe_n", m_txe_n, 1'b0);
    check("idle_tx_ready", m_tx_ready, 1'b1);
    check("idle_data_oe", m_oe, 1'b0);
    check("idle_perr", m_perr, 1'b0);
    $display("[TB] reset and idle checks done");

    run_read(4, 1'b0);
    run_read(12, 1'b1);
    run_write(16, 1'b0);
    run_write(24, 1'b1);

    // Overflow on the 8-deep instance: 10 writes ignoring ft_txe_n, host not draining.
    do_reset();
    host_rx_ready = 1'b0; ft_be_in = 4'hF;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      ft_data_in = w; ft_wr_n = 1'b0;
      if (i < 8) uq.push_back(w);
      tick();
`ifndef FT601_EMU_THROTTLE_EN
      if (i == 4) check("small_txe_free4", s_txe_n, 1'b0);
`endif
      if (i == 5) check("small_txe_free3", s_txe_n, 1'b1);
    end
    ft_wr_n = 1'b1;
    tick();
    check("small_drop", s_drop, 16'd2);
    check("small_txe_full", s_txe_n, 1'b1);
    check("small_perr", s_perr, 1'b0);
    host_rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("small_rx_valid", s_rx_valid, 1'b1);
      check("small_rx_data", s_rx_data, uq[0]);
      void'(uq.pop_front());
      tick();
    end
    check("small_rx_empty", s_rx_valid, 1'b0);
    host_rx_ready = 1'b0;
    $display("[TB] overflow: drop_cnt=%0d", s_drop);

    // Reset while both FIFOs of the main instance hold data.
    for (int i = 0; i < 3; i++) begin
      host_tx_data = $urandom; host_tx_valid = 1'b1;
      tick();
    end
    host_tx_valid = 1'b0;
    tick(); tick();
    check("pre_rst_rxf_n", m_rxf_n, 1'b0);
    do_reset();
    repeat (3) tick();
    check("discard_rxf_n", m_rxf_n, 1'b1);
    check("discard_rx_valid", m_rx_valid, 1'b0);
    $display("[TB] reset discard done");

    // Protocol violations.
    ft_oe_n = 1'b0; ft_wr_n = 1'b0;
    repeat (3) tick();
    ft_oe_n = 1'b1; ft_wr_n = 1'b1;
    repeat (2) tick();
    check("perr_contention", m_perr, 1'b1);
    repeat (5) tick();
    check("perr_sticky", m_perr, 1'b1);
    do_reset();
    check("perr_cleared", m_perr, 1'b0);
    ft_rd_n = 1'b0;
    tick();
    ft_rd_n = 1'b1;
    tick();
    check("perr_rd_no_oe", m_perr, 1'b1);
    do_reset();
    ft_be_in = 4'h7; ft_data_in = $urandom; ft_wr_n = 1'b0;
    tick();
    ft_wr_n = 1'b1; ft_be_in = 4'hF;
    tick();
    check("perr_bad_be", m_perr, 1'b1);
    $display("[TB] protocol error checks done");

    // ft_txe_n with an empty up FIFO over two full throttle periods.
    do_reset();
    repeat (4) tick();
    txe_hi = 0;
    for (int i = 0; i < 128; i++) begin
      if (m_txe_n) txe_hi++;
      tick();
    end
`ifdef FT601_EMU_THROTTLE_EN
    exp_txe_hi = 12;
`else
    exp_txe_hi = 0;
`endif
    check("txe_high_cycles", txe_hi, exp_txe_hi);
    $display("[TB] txe high cycles in 128: %0d", txe_hi);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
